// File: rtl/multicycle_cpu.sv
// Multi-cycle MIPS-subset core with a single req/ack memory port and an IF/ID/EX/MEM/WB sequencer.
// Define JUMP_EN to add the j instruction (opcode 0x02), which retires in ID.
module multicycle_cpu #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              instr_done_o,
  input  logic [4:0]        dbg_reg_addr_i,
  output logic [31:0]       dbg_reg_data_o
);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_BEQ = 6'h04,
                         OP_ADDI  = 6'h08, OP_SLTI = 6'h0A, OP_LW  = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;

  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB} state_t;

  state_t             state, state_nxt;
  logic               run_q;
  logic [31:0]        pc, ir, mdr;
  logic signed [31:0] a_r, b_r, alu_out_r;
  logic [31:0]        regs [32];

  logic [5:0]         op, fn;
  logic [4:0]         rs, rt, rd, dest;
  logic signed [31:0] imm_sx;
  logic               is_rtype_ok, is_imm_alu, is_lw, is_sw, is_beq, is_j;

  function automatic logic signed [31:0] alu_op(
    input logic [5:0]         opc,
    input logic [5:0]         fnc,
    input logic signed [31:0] a,
    input logic signed [31:0] b,
    input logic signed [31:0] imm
  );
    alu_op = '0;
    case (opc)
      OP_RTYPE: begin
        case (fnc)
          F_ADD:   alu_op = a + b;
          F_SUB:   alu_op = a - b;
          F_AND:   alu_op = a & b;
          F_OR:    alu_op = a | b;
          F_SLT:   alu_op = (a < b) ? 32'sd1 : 32'sd0;
          default: alu_op = '0;
        endcase
      end
      OP_ADDI: alu_op = a + imm;
      OP_SLTI: alu_op = (a < imm) ? 32'sd1 : 32'sd0;
      default: alu_op = '0;
    endcase
  endfunction

  assign op     = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign fn     = ir[5:0];
  assign imm_sx = {{16{ir[15]}}, ir[15:0]};

  assign is_rtype_ok = (op == OP_RTYPE) && (fn inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT});
  assign is_imm_alu  = (op == OP_ADDI) || (op == OP_SLTI);
  assign is_lw       = (op == OP_LW);
  assign is_sw       = (op == OP_SW);
  assign is_beq      = (op == OP_BEQ);
`ifdef JUMP_EN
  assign is_j        = (op == OP_J);
`else
  assign is_j        = 1'b0;
`endif
  assign dest        = (op == OP_RTYPE) ? rd : rt;

  assign dbg_reg_data_o = (dbg_reg_addr_i == 5'd0) ? 32'h0 : regs[dbg_reg_addr_i];

  // run_q keeps the port idle for the first cycle after reset so a fetch never overlaps the reset edge
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= S_IF;
      run_q <= 1'b0;
    end else begin
      state <= state_nxt;
      run_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    instr_done_o = 1'b0;
    case (state)
      S_IF: begin
        if (run_q) begin
          mem_req_o  = 1'b1;
          mem_addr_o = pc[ADDR_W-1:0];
          if (mem_ack_i) state_nxt = S_ID;
        end
      end
      S_ID: begin
        if (is_j) begin
          instr_done_o = 1'b1;
          state_nxt    = S_IF;
        end else begin
          state_nxt = S_EX;
        end
      end
      S_EX: begin
        if (is_rtype_ok || is_imm_alu) begin
          state_nxt = S_WB;
        end else if (is_lw || is_sw) begin
          state_nxt = S_MEM;
        end else begin
          instr_done_o = 1'b1;
          state_nxt    = S_IF;
        end
      end
      S_MEM: begin
        mem_req_o   = 1'b1;
        mem_we_o    = is_sw;
        mem_addr_o  = alu_out_r[ADDR_W-1:0];
        mem_wdata_o = b_r;
        if (mem_ack_i) begin
          instr_done_o = is_sw;
          state_nxt    = is_sw ? S_IF : S_WB;
        end
      end
      S_WB: begin
        instr_done_o = 1'b1;
        state_nxt    = S_IF;
      end
      default: state_nxt = S_IF;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc        <= PC_RESET;
      ir        <= '0;
      a_r       <= '0;
      b_r       <= '0;
      alu_out_r <= '0;
      mdr       <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_IF: begin
          if (mem_req_o && mem_ack_i) begin
            ir <= mem_rdata_i;
            pc <= pc + 32'd4;
          end
        end
        // branch target is precomputed from the already-incremented PC
        S_ID: begin
          a_r       <= regs[rs];
          b_r       <= regs[rt];
          alu_out_r <= pc + (imm_sx << 2);
          if (is_j) pc <= {pc[31:28], ir[25:0], 2'b00};
        end
        S_EX: begin
          if (is_beq) begin
            if (a_r == b_r) pc <= alu_out_r;
          end else if (is_rtype_ok || is_imm_alu) begin
            alu_out_r <= alu_op(op, fn, a_r, b_r, imm_sx);
          end else if (is_lw || is_sw) begin
            alu_out_r <= a_r + imm_sx;
          end
        end
        S_MEM: begin
          if (mem_ack_i && is_lw) mdr <= mem_rdata_i;
        end
        S_WB: begin
          if (dest != 5'd0) regs[dest] <= is_lw ? mdr : alu_out_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multicycle_cpu.md
Name: multicycle_cpu

Overview:
- Multi-cycle MIPS-subset CPU core; successor to the single-cycle CPU.
- One unified memory port with a req/ack handshake, so instruction and data memory can have variable latency.
- Internal FSM sequences IF/ID/EX/MEM/WB; PC, register file and the IR/A/B/ALUOut/MDR holding registers are internal.
- Debug read port and retire pulse are provided for verification.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, memory address width; mem_addr_o carries PC/ALUOut bits [ADDR_W-1:0].

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  synchronous, active-low reset.
- mem_req_o  out  1  memory request valid.
- mem_we_o  out  1  1 = write (sw), 0 = read.
- mem_addr_o  out  ADDR_W  byte address.
- mem_wdata_o  out  32  store data (B register).
- mem_rdata_i  in  32  read data; valid when mem_ack_i = 1.
- mem_ack_i  in  1  transaction complete; sampled only while mem_req_o = 1.
- instr_done_o  out  1  one-cycle pulse when an instruction retires.
- dbg_reg_addr_i  in  5  debug register select.
- dbg_reg_data_o  out  32  combinational read of register dbg_reg_addr_i; $0 reads 0.

Behaviour:
- Reset (rst_i = 0 at a clock edge):
  - PC <= PC_RESET; all 32 registers, IR, A, B, ALUOut and MDR <= 0; state <= IF.
  - mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0, instr_done_o = 0.
  - A reset mid-transaction abandons it; mem_req_o is low in the cycle after the reset edge; no register or memory side effect commits.
- Supported ISA:
  - R-type (op 0x00), funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - addi 0x08, slti 0x0A, beq 0x04, lw 0x23, sw 0x2B.
  - Any other opcode or funct executes as a NOP: PC+4, retires in EX.
- Arithmetic: 32-bit two's complement, overflow wraps with no trap; slt/slti compare signed; immediates are sign-extended.
- FSM states and transitions:
  - IF: mem_req_o = 1, mem_we_o = 0, mem_addr_o = PC. Held until mem_ack_i. On ack: IR <= mem_rdata_i, PC <= PC+4, go to ID. An ack in the same cycle as the request is legal (zero-wait).
  - ID: A <= reg[rs], B <= reg[rt], ALUOut <= PC + (sext(imm) << 2), using the already-incremented PC. Go to EX.
  - EX, beq: if A == B then PC <= ALUOut. Pulse instr_done_o, go to IF.
  - EX, R-type / addi / slti: ALUOut <= result, go to WB.
  - EX, lw / sw: ALUOut <= A + sext(imm), go to MEM.
  - EX, NOP: pulse instr_done_o, go to IF.
  - MEM: mem_req_o = 1, mem_addr_o = ALUOut, mem_we_o = 1 for sw, mem_wdata_o = B. Held until ack.
    - lw: MDR <= mem_rdata_i, go to WB.
    - sw: pulse instr_done_o, go to IF.
  - WB: destination is rd for R-type, rt for I-type; data is ALUOut, or MDR for lw. Writes to $0 are discarded. Pulse instr_done_o, go to IF.
- Latency with zero-wait memory:
  - beq / NOP: 3 cycles.
  - R-type / addi / slti / sw: 4 cycles.
  - lw: 5 cycles.
  - Each wait cycle on the memory port adds one cycle.
- Handshake rules:
  - mem_addr_o, mem_we_o and mem_wdata_o stay stable while mem_req_o = 1 and ack has not been seen.
  - mem_req_o drops in the cycle after the ack.
- PC wraps modulo 2^32. Misaligned addresses are passed through unchanged.

Optional Feature:
- Macro JUMP_EN.
- Defined: opcode 0x02 (j) is supported. In ID, PC <= {PC[31:28], IR[25:0], 2'b00}, then pulse instr_done_o and go to IF (2 cycles with zero-wait memory).
- Undefined: opcode 0x02 executes as a NOP (3 cycles, PC+4).

Test Plan:
- Reset: hold rst_i = 0 for 2 cycles with PC_RESET = 32'h100 -> first request after release has mem_addr_o = 32'h100; dbg reads 0 for every register.
- ALU sequence, zero-wait memory:
  - addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; sub $4,$2,$1; slt $5,$2,$1.
  - Expected: $3 = 2, $4 = 32'hFFFF_FFF8, $5 = 1.
  - Each addi/R-type retires 4 cycles apart.
- Memory wait states, ack delayed 3 cycles:
  - sw $1,8($0) then lw $6,8($0) -> $6 = 5.
  - Address, we and wdata stay stable through the wait; lw retires at 5 + 2×3 = 11 cycles after its fetch starts.
- Branch:
  - beq $1,$1,+2 at PC 0x20 -> next fetch at 0x2C.
  - beq $1,$2,+2 -> next fetch at 0x24.
- Corner cases:
  - addi $0,$0,7 -> $0 stays 0.
  - addi $7,$1,32'h7FFF... overflow wraps: 0x7FFFFFFF + 1 = 0x80000000.
  - Opcode 0x3F -> NOP, next fetch at PC+4.
  - rst_i low during an IF wait -> mem_req_o drops; fetch restarts at PC_RESET.
- JUMP_EN:
  - j 0x40 at PC 0x1000_0000 -> next fetch at 0x1000_0100 when defined.
  - Fetch at 0x1000_0004 when undefined.
